// File: rtl/sc_spil_pkg.sv
// sc_spil_pkg: shared types and constants for the SPI Lite transaction arbiter.
package sc_spil_pkg;

    // Width of the grant-to-complete watchdog counter.
    localparam int SC_SPIL_TMO_W = 16;

    // Sequencer states; the timeout path shares the DONE slot.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } sc_spil_arb_state_e;

    // Payload captured from the winning requester at grant time.
    typedef struct packed {
        logic [4:0]  cssel;
        logic [8:0]  dwidth;
        logic [31:0] txdata;
        logic        lock;
    } sc_spil_arb_req_s;

endpackage

// File: rtl/sc_spil_rr_arb.sv
// sc_spil_rr_arb: combinational round-robin pick. Searches upward from
// i_ptr + 1 and wraps at NUM_OF_REQ-1 -> 0, so i_ptr itself has lowest priority.
module sc_spil_rr_arb #(
    parameter int NUM_OF_REQ = 4
) (
    input  logic [NUM_OF_REQ-1:0] i_req,
    input  logic [2:0]            i_ptr,
    output logic [NUM_OF_REQ-1:0] o_win_oh,
    output logic [2:0]            o_win_idx,
    output logic                  o_win_any
);

    logic w_hit;

    // Two passes: first the indices above the pointer, then the wrapped ones.
    always_comb begin
        o_win_any = 1'b0;
        o_win_idx = 3'd0;
        w_hit     = 1'b0;
        for (int i = 0; i < NUM_OF_REQ; i++) begin
            w_hit     = !o_win_any && i_req[i] && (i > int'(i_ptr));
            o_win_idx = w_hit ? 3'(i) : o_win_idx;
            o_win_any = o_win_any | w_hit;
        end
        for (int i = 0; i < NUM_OF_REQ; i++) begin
            w_hit     = !o_win_any && i_req[i] && (i <= int'(i_ptr));
            o_win_idx = w_hit ? 3'(i) : o_win_idx;
            o_win_any = o_win_any | w_hit;
        end
        o_win_oh = o_win_any ? (NUM_OF_REQ'(1) << o_win_idx) : '0;
    end

endmodule

// File: rtl/sc_spil_arb.sv
// sc_spil_arb: shares one SPI Lite core between NUM_OF_REQ requesters with
// round-robin arbitration, chip-select lock and one transaction in flight.
// Optional grant-to-complete watchdog: define SC_SPIL_ARB_TIMEOUT_EN.
module sc_spil_arb
    import sc_spil_pkg::*;
#(
    parameter int                       NUM_OF_REQ  = 4,
    parameter logic [SC_SPIL_TMO_W-1:0] TIMEOUT_CYC = 16'd65535
) (
    input  logic                      SYSCLK,
    input  logic                      SYSRSTB,
    input  logic [NUM_OF_REQ-1:0]     REQ,
    input  logic [NUM_OF_REQ-1:0]     LOCK,
    input  logic [5*NUM_OF_REQ-1:0]   REQ_CSSEL,
    input  logic [9*NUM_OF_REQ-1:0]   REQ_DWIDTH,
    input  logic [32*NUM_OF_REQ-1:0]  REQ_TXDATA,
    output logic [NUM_OF_REQ-1:0]     GNT,
    output logic [NUM_OF_REQ-1:0]     DONE,
    output logic [NUM_OF_REQ-1:0]     ERR,
    output logic [31:0]               RXDATA_OUT,
    output logic [2:0]                OWNER,
    output logic [4:0]                CSSEL,
    output logic                      CSEXTEND,
    output logic [8:0]                DWIDTH,
    output logic [31:0]               TXDATA,
    output logic                      TXSTART,
    input  logic                      SPIBUSY,
    input  logic                      SPICOMPLETE,
    input  logic [31:0]               RXDATA
);

    sc_spil_arb_state_e    r_state, w_state_nxt;
    sc_spil_arb_req_s      r_payload, w_payload_nxt, w_win_payload;
    logic [NUM_OF_REQ-1:0] r_gnt, r_done, r_err;
    logic [NUM_OF_REQ-1:0] w_gnt_nxt, w_done_nxt, w_err_nxt;
    logic                  r_txstart, w_txstart_nxt;
    logic [31:0]           r_rxdata, w_rxdata_nxt;
    logic                  r_lock, w_lock_nxt;
    logic [2:0]            r_owner, w_owner_nxt, r_ptr, w_ptr_nxt;
    logic [NUM_OF_REQ-1:0] w_elig, w_win_oh, w_owner_oh;
    logic [2:0]            w_win_idx;
    logic                  w_win_any;
    logic                  w_timeout;

    assign w_owner_oh = NUM_OF_REQ'(1) << r_owner;

    // While locked only the current owner may be granted again.
    always_comb begin
        if (r_lock) begin
            w_elig = REQ & w_owner_oh;
        end else begin
            w_elig = REQ;
        end
    end

    sc_spil_rr_arb #(
        .NUM_OF_REQ (NUM_OF_REQ)
    ) u_rr_arb (
        .i_req     (w_elig),
        .i_ptr     (r_ptr),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx),
        .o_win_any (w_win_any)
    );

    // One-hot select of the winner's payload fields.
    always_comb begin
        w_win_payload = '0;
        for (int i = 0; i < NUM_OF_REQ; i++) begin
            w_win_payload.cssel  = w_win_payload.cssel  | (REQ_CSSEL[i*5 +: 5]   & {5{w_win_oh[i]}});
            w_win_payload.dwidth = w_win_payload.dwidth | (REQ_DWIDTH[i*9 +: 9]  & {9{w_win_oh[i]}});
            w_win_payload.txdata = w_win_payload.txdata | (REQ_TXDATA[i*32 +: 32] & {32{w_win_oh[i]}});
            w_win_payload.lock   = w_win_payload.lock   | (LOCK[i] & w_win_oh[i]);
        end
    end

`ifdef SC_SPIL_ARB_TIMEOUT_EN
    logic [SC_SPIL_TMO_W-1:0] r_tmo_cnt;

    // Watchdog: held at zero in IDLE (so cleared on grant), counts in START/BUSY.
    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_START) || (r_state == ST_BUSY)) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_timeout = ((r_state == ST_START) || (r_state == ST_BUSY)) &&
                       (r_tmo_cnt == (TIMEOUT_CYC - 16'd1));
`else
    logic w_unused_tmo;
    assign w_timeout    = 1'b0;
    assign w_unused_tmo = ^TIMEOUT_CYC;
`endif

    // State register.
    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a completion always wins over a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_win_any) w_state_nxt = ST_START;
                else           w_state_nxt = ST_IDLE;
            end
            ST_START: begin
                if (SPICOMPLETE || w_timeout) w_state_nxt = ST_DONE;
                else if (SPIBUSY)             w_state_nxt = ST_BUSY;
                else                          w_state_nxt = ST_START;
            end
            ST_BUSY: begin
                if (SPICOMPLETE || w_timeout) w_state_nxt = ST_DONE;
                else                          w_state_nxt = ST_BUSY;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output / datapath next values; all outputs are registered from these.
    always_comb begin
        w_gnt_nxt     = '0;
        w_done_nxt    = '0;
        w_err_nxt     = '0;
        w_txstart_nxt = 1'b0;
        w_payload_nxt = r_payload;
        w_rxdata_nxt  = r_rxdata;
        w_lock_nxt    = r_lock;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_win_any) begin
                    w_gnt_nxt     = w_win_oh;
                    w_txstart_nxt = 1'b1;
                    w_payload_nxt = w_win_payload;
                    w_owner_nxt   = w_win_idx;
                    w_ptr_nxt     = w_win_idx;
                end else begin
                    w_txstart_nxt = 1'b0;
                end
            end
            ST_START, ST_BUSY: begin
                if (SPICOMPLETE) begin
                    w_done_nxt   = w_owner_oh;
                    w_rxdata_nxt = RXDATA;
                end else if (w_timeout) begin
                    // Abandon the transfer: drop CS extension so the lock clears.
                    w_err_nxt          = w_owner_oh;
                    w_payload_nxt.lock = 1'b0;
                end else begin
                    w_txstart_nxt = (r_state == ST_START) && !SPIBUSY;
                end
            end
            ST_DONE: w_lock_nxt = r_payload.lock;
            default: w_lock_nxt = 1'b0;
        endcase
    end

    // Registered outputs and arbitration bookkeeping.
    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_txstart <= 1'b0;
            r_payload <= '0;
            r_rxdata  <= 32'd0;
            r_lock    <= 1'b0;
            r_owner   <= 3'd0;
            r_ptr     <= 3'(NUM_OF_REQ - 1);
        end else begin
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_txstart <= w_txstart_nxt;
            r_payload <= w_payload_nxt;
            r_rxdata  <= w_rxdata_nxt;
            r_lock    <= w_lock_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    assign GNT        = r_gnt;
    assign DONE       = r_done;
    assign ERR        = r_err;
    assign TXSTART    = r_txstart;
    assign RXDATA_OUT = r_rxdata;
    assign OWNER      = r_owner;
    assign CSSEL      = r_payload.cssel;
    assign DWIDTH     = r_payload.dwidth;
    assign TXDATA     = r_payload.txdata;
    assign CSEXTEND   = r_payload.lock;

endmodule

// File: tb/tb_sc_spil_arb.sv
// tb_sc_spil_arb: directed vector table plus hand-written multi-cycle sequences.
module tb_sc_spil_arb;

    logic         SYSCLK;
    logic         SYSRSTB;
    logic [3:0]   REQ;
    logic [3:0]   LOCK;
    logic [19:0]  REQ_CSSEL;
    logic [35:0]  REQ_DWIDTH;
    logic [127:0] REQ_TXDATA;
    logic [3:0]   GNT, DONE, ERR;
    logic [31:0]  RXDATA_OUT;
    logic [2:0]   OWNER;
    logic [4:0]   CSSEL;
    logic         CSEXTEND;
    logic [8:0]   DWIDTH;
    logic [31:0]  TXDATA;
    logic         TXSTART;
    logic         SPIBUSY;
    logic         SPICOMPLETE;
    logic [31:0]  RXDATA;

    int n_tests = 0;
    int n_fail  = 0;

    sc_spil_arb #(
        .NUM_OF_REQ  (4),
        .TIMEOUT_CYC (16'd16)
    ) dut (
        .SYSCLK      (SYSCLK),
        .SYSRSTB     (SYSRSTB),
        .REQ         (REQ),
        .LOCK        (LOCK),
        .REQ_CSSEL   (REQ_CSSEL),
        .REQ_DWIDTH  (REQ_DWIDTH),
        .REQ_TXDATA  (REQ_TXDATA),
        .GNT         (GNT),
        .DONE        (DONE),
        .ERR         (ERR),
        .RXDATA_OUT  (RXDATA_OUT),
        .OWNER       (OWNER),
        .CSSEL       (CSSEL),
        .CSEXTEND    (CSEXTEND),
        .DWIDTH      (DWIDTH),
        .TXDATA      (TXDATA),
        .TXSTART     (TXSTART),
        .SPIBUSY     (SPIBUSY),
        .SPICOMPLETE (SPICOMPLETE),
        .RXDATA      (RXDATA)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait for a grant, check it, then run the core through BUSY and COMPLETE.
    task automatic xfer(input int exp_wait, input logic [3:0] exp_gnt, input logic exp_cse,
                        input string tag);
        int   k;
        logic got;
        k   = 0;
        got = 1'b0;
        while (!got && k < 30) begin
            @(negedge SYSCLK);
            k++;
            if (GNT != 4'd0) got = 1'b1;
        end
        chk({tag, " gnt"}, 32'(GNT), 32'(exp_gnt));
        if (exp_wait > 0) chk({tag, " gap"}, 32'(k), 32'(exp_wait));
        chk({tag, " csextend"}, 32'(CSEXTEND), 32'(exp_cse));
        chk({tag, " txstart"}, 32'(TXSTART), 32'd1);
        if (got) begin
            SPIBUSY = 1'b1;
            @(negedge SYSCLK);
            chk({tag, " txstart drop"}, 32'(TXSTART), 32'd0);
            SPICOMPLETE = 1'b1;
            RXDATA      = 32'hD00D_0000 | 32'(exp_gnt);
            @(negedge SYSCLK);
            SPICOMPLETE = 1'b0;
            SPIBUSY     = 1'b0;
            chk({tag, " done"}, 32'(DONE), 32'(exp_gnt));
            chk({tag, " rxdata"}, RXDATA_OUT, 32'hD00D_0000 | 32'(exp_gnt));
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        busy;
        logic        comp;
        logic [31:0] rx;
        logic [3:0]  e_gnt;
        logic [3:0]  e_done;
        logic        e_txs;
        logic [31:0] e_rx;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int   k;
        logic got;

        tbl[0] = '{4'b0001, 1'b0, 1'b0, 32'h0,         4'b0001, 4'b0000, 1'b1, 32'h0};
        tbl[1] = '{4'b0000, 1'b0, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b1, 32'h0};
        tbl[2] = '{4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 32'h0};
        tbl[3] = '{4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 32'h0};
        tbl[4] = '{4'b0000, 1'b0, 1'b1, 32'h1234_5678, 4'b0000, 4'b0001, 1'b0, 32'h1234_5678};
        tbl[5] = '{4'b0000, 1'b0, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 32'h1234_5678};
        tbl[6] = '{4'b0001, 1'b0, 1'b0, 32'h0,         4'b0001, 4'b0000, 1'b1, 32'h1234_5678};
        tbl[7] = '{4'b0000, 1'b1, 1'b1, 32'hCAFE_F00D, 4'b0000, 4'b0001, 1'b0, 32'hCAFE_F00D};
        tbl[8] = '{4'b0000, 1'b0, 1'b0, 32'h0,         4'b0000, 4'b0000, 1'b0, 32'hCAFE_F00D};

        SYSRSTB     = 1'b0;
        REQ         = 4'd0;
        LOCK        = 4'd0;
        SPIBUSY     = 1'b0;
        SPICOMPLETE = 1'b0;
        RXDATA      = 32'd0;
        for (int i = 0; i < 4; i++) begin
            REQ_TXDATA[i*32 +: 32] = 32'hA5A5_0001 + 32'(i);
            REQ_CSSEL[i*5 +: 5]    = 5'(i + 1);
            REQ_DWIDTH[i*9 +: 9]   = 9'(8 + i);
        end

        // Reset state.
        repeat (2) @(negedge SYSCLK);
        chk("rst gnt", 32'(GNT), 32'd0);
        chk("rst done", 32'(DONE), 32'd0);
        chk("rst txstart", 32'(TXSTART), 32'd0);
        chk("rst csextend", 32'(CSEXTEND), 32'd0);
        chk("rst owner", 32'(OWNER), 32'd0);
        chk("rst rxdata", RXDATA_OUT, 32'd0);
        SYSRSTB = 1'b1;

        // Single requester transactions from the vector table.
        for (int i = 0; i < 9; i++) begin
            REQ         = tbl[i].req;
            SPIBUSY     = tbl[i].busy;
            SPICOMPLETE = tbl[i].comp;
            RXDATA      = tbl[i].rx;
            @(negedge SYSCLK);
            chk($sformatf("vec%0d gnt", i), 32'(GNT), 32'(tbl[i].e_gnt));
            chk($sformatf("vec%0d done", i), 32'(DONE), 32'(tbl[i].e_done));
            chk($sformatf("vec%0d txstart", i), 32'(TXSTART), 32'(tbl[i].e_txs));
            chk($sformatf("vec%0d rxdata", i), RXDATA_OUT, tbl[i].e_rx);
            chk($sformatf("vec%0d txdata", i), TXDATA, 32'hA5A5_0001);
            chk($sformatf("vec%0d cssel", i), 32'(CSSEL), 32'd1);
            chk($sformatf("vec%0d dwidth", i), 32'(DWIDTH), 32'd8);
        end
        SPIBUSY     = 1'b0;
        SPICOMPLETE = 1'b0;

        // Round robin with all requesters held high, starting fresh from reset.
        SYSRSTB = 1'b0;
        @(negedge SYSCLK);
        SYSRSTB = 1'b1;
        REQ     = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            xfer((i == 0) ? 1 : 2, 4'(1 << (i % 4)), 1'b0, $sformatf("rr%0d", i));
            chk($sformatf("rr%0d owner", i), 32'(OWNER), 32'(i % 4));
        end

        // Locked multi-word transfer by requester 1 while requester 2 waits.
        REQ  = 4'b0110;
        LOCK = 4'b0010;
        xfer(-1, 4'b0010, 1'b1, "lk1");
        xfer(2, 4'b0010, 1'b1, "lk2");
        REQ = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge SYSCLK);
            chk($sformatf("lkwait%0d gnt", i), 32'(GNT), 32'd0);
            chk($sformatf("lkwait%0d csextend", i), 32'(CSEXTEND), 32'd1);
        end
        REQ  = 4'b0110;
        LOCK = 4'b0000;
        xfer(-1, 4'b0010, 1'b0, "lk3");
        REQ = 4'b0100;
        xfer(2, 4'b0100, 1'b0, "lk4");

        // Reset asserted during BUSY while a lock is held.
        REQ  = 4'b1000;
        LOCK = 4'b1000;
        xfer(-1, 4'b1000, 1'b1, "rs1");
        k   = 0;
        got = 1'b0;
        while (!got && k < 30) begin
            @(negedge SYSCLK);
            k++;
            if (GNT != 4'd0) got = 1'b1;
        end
        chk("rs2 gnt", 32'(GNT), 32'b1000);
        SPIBUSY = 1'b1;
        @(negedge SYSCLK);
        chk("rs2 busy csextend", 32'(CSEXTEND), 32'd1);
        #2;
        SYSRSTB = 1'b0;
        #1;
        chk("midrst txstart", 32'(TXSTART), 32'd0);
        chk("midrst csextend", 32'(CSEXTEND), 32'd0);
        chk("midrst owner", 32'(OWNER), 32'd0);
        chk("midrst rxdata", RXDATA_OUT, 32'd0);
        chk("midrst txdata", TXDATA, 32'd0);
        chk("midrst done", 32'(DONE), 32'd0);
        SPIBUSY = 1'b0;
        REQ     = 4'b1111;
        LOCK    = 4'b0000;
        @(negedge SYSCLK);
        SYSRSTB = 1'b1;
        xfer(1, 4'b0001, 1'b0, "postrst");

`ifdef SC_SPIL_ARB_TIMEOUT_EN
        // Core never completes: watchdog must fire and release the lock.
        REQ  = 4'b0110;
        LOCK = 4'b0010;
        k    = 0;
        got  = 1'b0;
        while (!got && k < 30) begin
            @(negedge SYSCLK);
            k++;
            if (GNT != 4'd0) got = 1'b1;
        end
        chk("tmo gnt", 32'(GNT), 32'b0010);
        k   = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(negedge SYSCLK);
            k++;
            if (ERR != 4'd0) got = 1'b1;
        end
        chk("tmo cycles", 32'(k), 32'd16);
        chk("tmo err", 32'(ERR), 32'b0010);
        chk("tmo done", 32'(DONE), 32'd0);
        chk("tmo txstart", 32'(TXSTART), 32'd0);
        chk("tmo csextend", 32'(CSEXTEND), 32'd0);
        chk("tmo rxdata", RXDATA_OUT, 32'hD00D_0001);
        xfer(2, 4'b0100, 1'b0, "aftertmo");
`else
        chk("err tied", 32'(ERR), 32'd0);
`endif

        REQ  = 4'd0;
        LOCK = 4'd0;
        repeat (2) @(negedge SYSCLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
